// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, ALU operation encodings and
// the packed control bundle carried from ID into EX.
package pipe_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic mem_to_reg;
  } ctrl_t;

  // An invalid slot must never carry live control into EX.
  function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
    return valid ? c : '0;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one ALU operand.
//   rs / rs_data          : registered source index and register-file data
//   exmem_* / memwb_*     : writeback sources from later stages
//   fwd                   : selected operand value
// EX/MEM is the younger producer, so it overrides MEM/WB. x0 is never forwarded.
module fwd_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] rs_data,
  input  logic            exmem_reg_write,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] fwd
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs);
  assign memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs);

  always_comb begin
    fwd = rs_data;
    if (memwb_hit) fwd = memwb_result;
    if (exmem_hit) fwd = exmem_result;
  end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding and
// load-use bubble insertion.
//   id_*            : decoded instruction from ID (captured on the clock edge)
//   stall / flush   : hold the stage / squash it to a bubble (flush wins)
//   exmem_*, memwb_*: forwarding sources
//   alu_in_a/b, alu_ctrl, ex_*: EX-cycle outputs, valid when ex_valid=1
//   load_use_stall  : freeze PC and IF/ID this cycle
//   bubble_cnt      : saturating count of load-use bubbles
module id_ex_fwd_stage #(
  parameter int unsigned XLEN = pipe_pkg::XLEN,
  parameter int unsigned REGW = pipe_pkg::REGW,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alu_src,
  input  logic [3:0]      id_alu_ctrl,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_branch,
  input  logic            id_mem_to_reg,
  input  logic            stall,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_in_a,
  output logic [XLEN-1:0] alu_in_b,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] ex_store_data,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_mem_to_reg,
  output logic            load_use_stall,
  output logic [CNTW-1:0] bubble_cnt
);

  import pipe_pkg::*;

  logic            ex_valid_q;
  ctrl_t           ex_ctrl_q;
  logic [REGW-1:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic [XLEN-1:0] ex_rs1_data_q, ex_rs2_data_q, ex_imm_q;
  logic            ex_alu_src_q;
  logic [3:0]      alu_ctrl_q;
  logic [CNTW-1:0] bubble_cnt_q;

  ctrl_t           id_ctrl;
  logic            load_use;
  logic [XLEN-1:0] fwd_a, fwd_b;

  assign id_ctrl = '{reg_write: id_reg_write, mem_read: id_mem_read, mem_write: id_mem_write,
                     branch: id_branch, mem_to_reg: id_mem_to_reg};

  // rs2 match counts regardless of alu_src: conservative, never misses a hazard.
  assign load_use = !stall && !flush && ex_valid_q && ex_ctrl_q.mem_read &&
                    (ex_rd_q != '0) && id_valid &&
                    ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_rd_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_alu_src_q  <= 1'b0;
      alu_ctrl_q    <= ALU_ADD;
      bubble_cnt_q  <= '0;
    end else if (flush) begin
      // Data fields are left as-is; a bubble only needs valid and control cleared.
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
    end else if (stall) begin
      ex_valid_q <= ex_valid_q;
    end else if (load_use) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      if (bubble_cnt_q != '1) bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end else begin
      ex_valid_q    <= id_valid;
      ex_ctrl_q     <= gate_ctrl(id_ctrl, id_valid);
      ex_rd_q       <= id_rd;
      ex_rs1_q      <= id_rs1;
      ex_rs2_q      <= id_rs2;
      ex_rs1_data_q <= id_rs1_data;
      ex_rs2_data_q <= id_rs2_data;
      ex_imm_q      <= id_imm;
      ex_alu_src_q  <= id_alu_src;
      alu_ctrl_q    <= id_alu_ctrl;
    end
  end

  fwd_unit #(.XLEN(XLEN), .REGW(REGW)) u_fwd_a (
    .rs              (ex_rs1_q),
    .rs_data         (ex_rs1_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd             (fwd_a)
  );

  fwd_unit #(.XLEN(XLEN), .REGW(REGW)) u_fwd_b (
    .rs              (ex_rs2_q),
    .rs_data         (ex_rs2_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd             (fwd_b)
  );

  assign ex_valid       = ex_valid_q;
  assign alu_in_a       = fwd_a;
  assign alu_in_b       = ex_alu_src_q ? ex_imm_q : fwd_b;
  assign alu_ctrl       = alu_ctrl_q;
  assign ex_store_data  = fwd_b;
  assign ex_rd          = ex_rd_q;
  assign ex_reg_write   = ex_ctrl_q.reg_write;
  assign ex_mem_read    = ex_ctrl_q.mem_read;
  assign ex_mem_write   = ex_ctrl_q.mem_write;
  assign ex_branch      = ex_ctrl_q.branch;
  assign ex_mem_to_reg  = ex_ctrl_q.mem_to_reg;
  assign load_use_stall = load_use;
  assign bubble_cnt     = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
module tb_id_ex_fwd_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_alu_src;
  logic [3:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write, id_branch, id_mem_to_reg;
  logic        stall, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [31:0] alu_in_a, alu_in_b, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg;
  logic        load_use_stall;
  logic [15:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  id_ex_fwd_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_branch(id_branch), .id_mem_to_reg(id_mem_to_reg),
    .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic asrc, input logic [3:0] op,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = asrc; id_alu_ctrl = op;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_branch = 1'b0; id_mem_to_reg = mr;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    expect_val(32'h0); check("reset_ex_valid", {31'b0, ex_valid});
    expect_val(32'h2); check("reset_alu_ctrl", {28'b0, alu_ctrl});
    tick();
    rst_n = 1'b1;

    // Valid SUB into EX, then async reset mid-cycle.
    set_id(1'b1, 5'd5, 5'd0, 5'd7, 32'h11, 32'h22, 32'h100, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0);
    expect_val(32'h1); expect_val(32'h6); expect_val(32'h7);
    tick();
    check("cap_ex_valid", {31'b0, ex_valid});
    check("cap_alu_ctrl", {28'b0, alu_ctrl});
    check("cap_ex_rd", {27'b0, ex_rd});
    #3 rst_n = 1'b0;
    #1;
    expect_val(32'h0); check("async_rst_ex_valid", {31'b0, ex_valid});
    expect_val(32'h2); check("async_rst_alu_ctrl", {28'b0, alu_ctrl});
    expect_val(32'h0); check("async_rst_bubble_cnt", {16'b0, bubble_cnt});
    expect_val(32'h0); check("async_rst_reg_write", {31'b0, ex_reg_write});
    #1 rst_n = 1'b1;

    // Forwarding on rs1=5, rs2=0.
    set_id(1'b1, 5'd5, 5'd0, 5'd7, 32'h11, 32'h22, 32'h100, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h1234;
    expect_val(32'h1234); #1 check("fwd_exmem_a", alu_in_a);
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'hBEEF;
    expect_val(32'h1234); #1 check("fwd_exmem_priority", alu_in_a);
    exmem_reg_write = 1'b0;
    expect_val(32'hBEEF); #1 check("fwd_memwb_a", alu_in_a);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h9999;
    memwb_rd = 5'd0; memwb_result = 32'h7777;
    expect_val(32'h22); #1 check("x0_guard_alu_in_b", alu_in_b);
    expect_val(32'h22); check("x0_guard_store_data", ex_store_data);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

    // lw x3, 8(x1)
    set_id(1'b1, 5'd1, 5'd0, 5'd3, 32'h40, 32'h0, 32'h8, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
    tick();
    expect_val(32'h1); check("lw_ex_mem_read", {31'b0, ex_mem_read});
    expect_val(32'h8); check("lw_alu_in_b_imm", alu_in_b);
    // add x4, x3, x2 depends on the load
    set_id(1'b1, 5'd3, 5'd2, 5'd4, 32'hAA, 32'hBB, 32'h0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    #1;
    expect_val(32'h1); check("load_use_detect", {31'b0, load_use_stall});
    tick();
    expect_val(32'h0); check("bubble_ex_valid", {31'b0, ex_valid});
    expect_val(32'h1); check("bubble_cnt_1", {16'b0, bubble_cnt});
    expect_val(32'h0); check("bubble_reg_write", {31'b0, ex_reg_write});
    expect_val(32'h0); check("bubble_no_restall", {31'b0, load_use_stall});
    tick();
    expect_val(32'h1); check("held_ex_valid", {31'b0, ex_valid});
    expect_val(32'h4); check("held_ex_rd", {27'b0, ex_rd});
    expect_val(32'hAA); check("held_alu_in_a", alu_in_a);

    // lw x6, 16(x1), then stall with a dependent instruction waiting in ID.
    set_id(1'b1, 5'd1, 5'd0, 5'd6, 32'h40, 32'h0, 32'h10, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd6, 5'(i + 8), 5'(i + 9), 32'(i + 32'h500), 32'h1, 32'(i), 1'b0,
             4'b0001, 1'b1, 1'b0, 1'b1);
      #1;
      expect_val(32'h0); check("stall_no_load_use", {31'b0, load_use_stall});
      tick();
      expect_val(32'h1); check("stall_ex_valid", {31'b0, ex_valid});
      expect_val(32'h6); check("stall_ex_rd", {27'b0, ex_rd});
      expect_val(32'h10); check("stall_alu_in_b", alu_in_b);
      expect_val(32'h40); check("stall_alu_in_a", alu_in_a);
      expect_val(32'h2); check("stall_alu_ctrl", {28'b0, alu_ctrl});
      expect_val(32'h1); check("stall_mem_read", {31'b0, ex_mem_read});
      expect_val(32'h0); check("stall_mem_write", {31'b0, ex_mem_write});
      expect_val(32'h1); check("stall_bubble_cnt", {16'b0, bubble_cnt});
    end
    stall = 1'b0;
    #1;
    expect_val(32'h1); check("unstall_load_use", {31'b0, load_use_stall});

    // Flush and stall together with a valid ID instruction: flush wins.
    flush = 1'b1; stall = 1'b1;
    #1;
    expect_val(32'h0); check("flush_masks_load_use", {31'b0, load_use_stall});
    tick();
    flush = 1'b0; stall = 1'b0;
    expect_val(32'h0); check("flush_ex_valid", {31'b0, ex_valid});
    expect_val(32'h0); check("flush_reg_write", {31'b0, ex_reg_write});
    expect_val(32'h1); check("flush_bubble_cnt", {16'b0, bubble_cnt});

    // Invalid ID slot: control captured as zero, data still captured.
    set_id(1'b0, 5'd1, 5'd2, 5'd9, 32'h31, 32'h32, 32'h0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1);
    tick();
    expect_val(32'h0); check("invalid_ex_valid", {31'b0, ex_valid});
    expect_val(32'h0); check("invalid_reg_write", {31'b0, ex_reg_write});
    expect_val(32'h0); check("invalid_mem_write", {31'b0, ex_mem_write});
    expect_val(32'h1); check("invalid_alu_ctrl", {28'b0, alu_ctrl});
    expect_val(32'h31); check("invalid_alu_in_a", alu_in_a);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_fwd_stage.md
Name: id_ex_fwd_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures decoded operands and control, then presents the ALU inputs (in_A, in_B, ALUControl) for the EX cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts one bubble; supports an external stall (hold) and a flush (branch taken).

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, register index width.
- CNTW, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1, id_rs2, id_rd  in  REGW each  register indices.
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_alu_src  in  1  1 = in_B takes the immediate.
- id_alu_ctrl  in  4  ALU op: 0010 ADD, 0110 SUB/BEQ, 0000 AND, 0001 OR.
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_mem_to_reg  in  1 each  control bits.
- stall  in  1  hold the stage (downstream backpressure).
- flush  in  1  squash the stage (taken branch).
- exmem_reg_write  in  1; exmem_rd  in  REGW; exmem_result  in  XLEN  EX/MEM forwarding source.
- memwb_reg_write  in  1; memwb_rd  in  REGW; memwb_result  in  XLEN  MEM/WB forwarding source.
- ex_valid  out  1  EX slot valid.
- alu_in_a, alu_in_b  out  XLEN  to ALU in_A/in_B.
- alu_ctrl  out  4  to ALUControl.
- ex_store_data  out  XLEN  forwarded rs2, for stores.
- ex_rd  out  REGW; ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg  out  1 each  registered control.
- load_use_stall  out  1  freeze PC and IF/ID this cycle.
- bubble_cnt  out  CNTW  count of inserted load-use bubbles.

Behaviour:
- Reset (async, rst_n=0):
  - All registered fields are 0, including ex_valid, all ex_* control bits, ex_rd and bubble_cnt.
  - alu_ctrl resets to 0010.
  - Combinational outputs then follow from the zeroed registers.
- load_use_stall (combinational) = ex_valid & ex_mem_read & ex_rd≠0 & id_valid & (ex_rd==id_rs1 | (ex_rd==id_rs2 & ~id_alu_src & ~id_mem_write==0 … ))
  - Simplified, decided rule: the rs2 match counts whenever ex_rd==id_rs2, regardless of alu_src.
  - Forced to 0 while stall=1 or flush=1.
- Register update per clock edge, priority high to low:
  - flush=1: load a bubble. ex_valid=0, all control bits 0; data fields don't-care, held.
  - stall=1: hold every register.
  - load_use_stall=1: load a bubble and increment bubble_cnt, saturating at all-ones.
  - Otherwise: capture all id_* fields; ex_valid=id_valid.
  - If id_valid=0, control bits are captured as 0.
- Flush together with stall: flush wins; the stage holds a bubble afterwards.
- Forwarding (combinational, on the registered ex_rs1/ex_rs2):
  - fwdA = exmem_result if exmem_reg_write & exmem_rd≠0 & exmem_rd==ex_rs1.
  - Else fwdA = memwb_result if memwb_reg_write & memwb_rd≠0 & memwb_rd==ex_rs1.
  - Else fwdA = the registered rs1 data.
  - fwdB is built the same way from ex_rs2.
  - EX/MEM always has priority over MEM/WB.
- alu_in_a = fwdA; alu_in_b = ex_alu_src ? ex_imm : fwdB; ex_store_data = fwdB.
- A bubble or an invalid slot still drives alu_in_a and alu_in_b from the held data.
  - The consumer qualifies with ex_valid; the ALU result is ignored.
- Latency: one cycle from the id_* inputs to the ex_* outputs.
- Register x0 is never forwarded and never triggers load-use.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU op constants (ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_OR=4'b0001).
  - XLEN and REGW.
  - A packed control-bundle typedef {reg_write, mem_read, mem_write, branch, mem_to_reg}.
- One sub-module, fwd_unit, is combinational forwarding-select logic, instantiated once per operand.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with ex_valid=1 → ex_valid=0, alu_ctrl=0010 and bubble_cnt=0 immediately, without waiting for a clock edge.
- EX/MEM forward: ex_rs1=5, exmem_rd=5, exmem_reg_write=1, exmem_result=0x1234 → alu_in_a=0x1234.
  - Also drive memwb_rd=5 with 0xBEEF → alu_in_a stays 0x1234.
- x0 guard: ex_rs2=0, exmem_rd=0, exmem_reg_write=1, alu_src=0 → alu_in_b equals the registered rs2 data, not exmem_result.
- Load-use:
  - Stimulus: lw x3 in EX, id_rs1=3, id_valid=1.
  - Expected: load_use_stall=1. Next edge ex_valid=0 and bubble_cnt=1; the following cycle the held ID instruction enters with ex_valid=1.
- Flush vs stall: flush=1 and stall=1 together with a valid ID instruction → next edge ex_valid=0 and ex_reg_write=0.
- Stall hold: stall=1 for 3 cycles with the id_* inputs changing → every ex_* output is unchanged; bubble_cnt is unchanged even if a load-use condition exists.
